// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg
//   Shared types and default sizing for the instruction-memory fetch
//   controller: the controller state enum, default address/data widths
//   and the default program-counter start value.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2
  } imem_state_t;

  localparam int IMEM_ADDR_W   = 6;
  localparam int IMEM_DATA_W   = 16;
  localparam int IMEM_RESET_PC = 0;

endpackage

// File: rtl/imem_ld_checksum.sv
// imem_ld_checksum
//   Running modulo-2^DATA_W sum of the words accepted from the loader.
//   Only instantiated when IMEM_LOAD_CHECKSUM_EN is defined.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (sum -> 0)
//   clear      zero the sum (start of a new load)
//   add_en     accumulate add_data this cycle
//   add_data   accepted loader word
//   sum        current checksum
module imem_ld_checksum
  import imem_ctrl_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] sum_reg;
  logic [DATA_W-1:0] sum_next;

  always_comb begin
    sum_next = sum_reg;
    if (clear)       sum_next = '0;
    else if (add_en) sum_next = sum_reg + add_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_reg <= '0;
    else     sum_reg <= sum_next;
  end

  assign sum = sum_reg;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Sequences an external 64x16 synchronous instruction RAM (read-first,
//   one-cycle latency, enable-gated output register). Bootstraps a program
//   from a streaming loader (LOAD), then fetches by PC and hands words to
//   the core over a valid/ready handshake (FETCH), with branch redirect and
//   halt back to IDLE.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   load_start, run_start          IDLE-only start pulses (load wins)
//   ld_valid/ld_data/ld_last       loader stream in, ld_ready out
//   branch_en, branch_target       PC redirect
//   halt                           stop fetching, back to IDLE
//   instr_valid/instr_data/instr_pc, instr_ready   core handshake
//   busy                           controller not in IDLE
//   mem_en/mem_we/mem_addr/mem_di  RAM control (combinational), mem_do RAM data
// Configuration:
//   IMEM_LOAD_CHECKSUM_EN  adds ld_checksum, the sum of accepted loader words
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W   = IMEM_ADDR_W,
  parameter int DATA_W   = IMEM_DATA_W,
  parameter int RESET_PC = IMEM_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              run_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
`ifdef IMEM_LOAD_CHECKSUM_EN
  output logic [DATA_W-1:0] ld_checksum,
`endif
  input  logic [DATA_W-1:0] mem_do
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

  imem_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] ld_ptr_reg, ld_ptr_next;
  logic              instr_valid_reg, instr_valid_next;
  logic [ADDR_W-1:0] instr_pc_reg, instr_pc_next;

  logic ld_fire;
  logic issue;

  assign ld_ready = (state_reg == LOAD);
  assign ld_fire  = ld_valid & ld_ready;
  // A word still waiting for the core blocks the RAM so its output register
  // (and therefore instr_data) holds through the stall.
  assign issue    = (state_reg == FETCH) & ~halt & ~branch_en &
                    (~instr_valid_reg | instr_ready);

  // RAM pins: load writes and fetch reads are mutually exclusive by state.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;
    if (ld_fire) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = ld_ptr_reg;
      mem_di   = ld_data;
    end else if (issue) begin
      mem_en   = 1'b1;
      mem_addr = pc_reg;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    ld_ptr_next      = ld_ptr_reg;
    instr_valid_next = instr_valid_reg;
    instr_pc_next    = instr_pc_reg;
    unique case (state_reg)
      IDLE: begin
        if (load_start) begin
          state_next  = LOAD;
          ld_ptr_next = '0;
        end else if (run_start) begin
          state_next = FETCH;
          pc_next    = PC_INIT;
        end
      end
      LOAD: begin
        if (ld_fire) begin
          ld_ptr_next = ld_ptr_reg + ADDR_W'(1);
          // Stop at the last word or when the memory is full, so excess
          // words are never accepted.
          if (ld_last || ld_ptr_reg == PTR_MAX) begin
            state_next = FETCH;
            pc_next    = PC_INIT;
          end
        end
      end
      FETCH: begin
        if (halt) begin
          state_next       = IDLE;
          instr_valid_next = 1'b0;
        end else if (branch_en) begin
          // Squash the presented word even if the core is taking it.
          pc_next          = branch_target;
          instr_valid_next = 1'b0;
        end else if (issue) begin
          pc_next          = pc_reg + ADDR_W'(1);
          instr_pc_next    = pc_reg;
          instr_valid_next = 1'b1;
        end else if (instr_valid_reg && instr_ready) begin
          instr_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      ld_ptr_reg      <= '0;
      instr_valid_reg <= 1'b0;
      instr_pc_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      ld_ptr_reg      <= ld_ptr_next;
      instr_valid_reg <= instr_valid_next;
      instr_pc_reg    <= instr_pc_next;
    end
  end

  assign instr_valid = instr_valid_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_data  = mem_do;
  assign busy        = (state_reg != IDLE);

`ifdef IMEM_LOAD_CHECKSUM_EN
  imem_ld_checksum #(
    .DATA_W (DATA_W)
  ) u_ld_checksum (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state_reg == IDLE) & load_start),
    .add_en   (ld_fire),
    .add_data (ld_data),
    .sum      (ld_checksum)
  );
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl
//   Directed bench for imem_fetch_ctrl with a behavioural 64x16 read-first
//   RAM (enable-gated output register) beside it. Inputs change 1 time unit
//   after the rising edge; outputs are checked before the next edge.
module tb_imem_fetch_ctrl;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start, run_start;
  logic          ld_valid, ld_last;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          branch_en;
  logic [AW-1:0] branch_target;
  logic          halt;
  logic          instr_valid, instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          busy;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di, mem_do;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [DW-1:0] ld_checksum;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .run_start     (run_start),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .ld_last       (ld_last),
    .ld_ready      (ld_ready),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .halt          (halt),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .busy          (busy),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_di        (mem_di),
`ifdef IMEM_LOAD_CHECKSUM_EN
    .ld_checksum   (ld_checksum),
`endif
    .mem_do        (mem_do)
  );

  // Behavioural RAM: read-first, output register updates only when enabled.
  logic [DW-1:0] ram [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_di;
      mem_do <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0] w1 [3];

  initial begin
    w1[0] = 16'h1111; w1[1] = 16'h2222; w1[2] = 16'h3333;
    rst = 1'b1; load_start = 0; run_start = 0; ld_valid = 0; ld_last = 0;
    ld_data = '0; branch_en = 0; branch_target = '0; halt = 0; instr_ready = 0;
    mem_do = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",        32'(busy), 0);
    check("rst_ld_ready",    32'(ld_ready), 0);
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_instr_pc",    32'(instr_pc), 0);
    check("rst_mem_en",      32'(mem_en), 0);
    check("rst_mem_we",      32'(mem_we), 0);
    check("rst_mem_addr",    32'(mem_addr), 0);
    check("rst_mem_di",      32'(mem_di), 0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("rst_checksum",    32'(ld_checksum), 0);
`endif
    rst = 1'b0;
    step;

    // ---- load three words, then run them ----
    load_start = 1; step; load_start = 0;
    check("t1_busy", 32'(busy), 1);
    check("t1_ld_ready", 32'(ld_ready), 1);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = w1[i]; ld_last = (i == 2);
      #1;
      check("t1_mem_en",   32'(mem_en), 1);
      check("t1_mem_we",   32'(mem_we), 1);
      check("t1_mem_addr", 32'(mem_addr), 32'(i));
      check("t1_mem_di",   32'(mem_di), 32'(w1[i]));
      step;
    end
    ld_valid = 0; ld_last = 0; instr_ready = 1;
    #1;
    check("t1_ld_ready_fetch", 32'(ld_ready), 0);
    check("t1_first_issue_en", 32'(mem_en), 1);
    check("t1_first_issue_we", 32'(mem_we), 0);
    check("t1_first_issue_addr", 32'(mem_addr), 0);
    for (int k = 0; k < 3; k++) begin
      step;
      check("t1_valid", 32'(instr_valid), 1);
      check("t1_pc",    32'(instr_pc), 32'(k));
      check("t1_data",  32'(instr_data), 32'(w1[k]));
    end
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("t1_checksum_hold", 32'(ld_checksum), 32'h6666);
`endif
    halt = 1; #1;
    check("t1_halt_mem_en", 32'(mem_en), 0);
    step; halt = 0;
    check("t1_halt_busy",  32'(busy), 0);
    check("t1_halt_valid", 32'(instr_valid), 0);

    // ---- full 64-word load (load beats run), wrap, branch, stall ----
    load_start = 1; run_start = 1; step; load_start = 0; run_start = 0;
    check("t2_load_wins", 32'(ld_ready), 1);
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1; ld_data = 16'hA000 + 16'(i); ld_last = 0;
      #1;
      check("t2_ld_addr", 32'(mem_addr), 32'(i));
      step;
    end
    // ld_valid still high: the 65th word must not be taken.
    check("t2_ld_ready_full", 32'(ld_ready), 0);
    check("t2_no_excess_we",  32'(mem_we), 0);
    check("t2_fetch_busy",    32'(busy), 1);
    ld_valid = 0;
    for (int k = 0; k < 68; k++) begin
      step;
      check("t2_pc",   32'(instr_pc), 32'(k % 64));
      check("t2_data", 32'(instr_data), 32'h0000A000 + 32'(k % 64));
    end
    // instr_pc = 3 valid: redirect to 0x20
    branch_en = 1; branch_target = 6'h20; #1;
    check("t3_br_no_issue", 32'(mem_en), 0);
    step; branch_en = 0;
    check("t3_br_squash", 32'(instr_valid), 0);
    #1;
    check("t3_br_addr", 32'(mem_addr), 32'h20);
    step;
    check("t3_br_valid", 32'(instr_valid), 1);
    check("t3_br_pc",    32'(instr_pc), 32'h20);
    check("t3_br_data",  32'(instr_data), 32'hA020);
    // redirect to 5 with a stray load_start that must be ignored
    branch_en = 1; branch_target = 6'd5; load_start = 1;
    step; branch_en = 0; load_start = 0;
    check("t3_start_ignored", 32'(ld_ready), 0);
    step;
    check("t4_pc5", 32'(instr_pc), 5);
    instr_ready = 0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("t4_stall_mem_en", 32'(mem_en), 0);
      step;
      check("t4_stall_valid", 32'(instr_valid), 1);
      check("t4_stall_pc",    32'(instr_pc), 5);
      check("t4_stall_data",  32'(instr_data), 32'hA005);
    end
    instr_ready = 1;
    step;
    check("t4_release_pc",   32'(instr_pc), 6);
    check("t4_release_data", 32'(instr_data), 32'hA006);
    halt = 1; branch_en = 1; branch_target = 6'h10;
    step; halt = 0; branch_en = 0;
    check("t4_halt_busy",  32'(busy), 0);
    check("t4_halt_valid", 32'(instr_valid), 0);
    check("t4_halt_mem_en", 32'(mem_en), 0);

    // ---- reset in the middle of a load ----
    load_start = 1; step; load_start = 0;
    ld_valid = 1; ld_data = 16'hBEEF; step;
    ld_data = 16'hCAFE; step;
    ld_data = 16'h5A5A;
    rst = 1; #1;
    check("t5_rst_ld_ready", 32'(ld_ready), 0);
    check("t5_rst_busy",     32'(busy), 0);
    check("t5_rst_mem_en",   32'(mem_en), 0);
    check("t5_rst_mem_we",   32'(mem_we), 0);
    check("t5_rst_mem_addr", 32'(mem_addr), 0);
    check("t5_rst_mem_di",   32'(mem_di), 0);
    check("t5_rst_pc",       32'(instr_pc), 0);
    ld_valid = 0; ld_data = '0;
    step; rst = 0; step;
    run_start = 1; step; run_start = 0;
    step;
    check("t5_pc0",   32'(instr_pc), 0);
    check("t5_data0", 32'(instr_data), 32'hBEEF);
    step;
    check("t5_pc1",   32'(instr_pc), 1);
    check("t5_data1", 32'(instr_data), 32'hCAFE);
    step;
    check("t5_data2_untouched", 32'(instr_data), 32'hA002);
    halt = 1; step; halt = 0;
    check("t5_halt_busy", 32'(busy), 0);

`ifdef IMEM_LOAD_CHECKSUM_EN
    // ---- checksum wraps modulo 2^16 ----
    load_start = 1; step; load_start = 0;
    check("t6_cks_cleared", 32'(ld_checksum), 0);
    ld_valid = 1; ld_data = 16'hFFFF; step;
    ld_data = 16'h0002; ld_last = 1; step;
    ld_valid = 0; ld_last = 0;
    check("t6_cks", 32'(ld_checksum), 32'h0001);
    halt = 1; step; halt = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Controller that sequences the 64 x 16 synchronous instruction memory (always-read, read-first, one-cycle read latency, enable-gated output register). It owns the memory's en/we/addr/di pins. It first bootstraps a program into the memory from a streaming loader, then fetches instructions by program counter and presents them to the core through a valid/ready handshake. It supports branch redirect and halt.

## Interface
Parameters:
- ADDR_W, 6, memory address width; PC width
- DATA_W, 16, instruction width
- RESET_PC, 0, PC value on entering FETCH

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  pulse in IDLE: enter LOAD
- run_start  in  1  pulse in IDLE: enter FETCH, program already resident
- ld_valid  in  1  loader word valid
- ld_data  in  DATA_W  loader word
- ld_last  in  1  marks final loader word
- ld_ready  out  1  controller accepts loader word
- branch_en  in  1  redirect PC this cycle
- branch_target  in  ADDR_W  redirect address
- halt  in  1  stop fetching, return to IDLE
- instr_valid  out  1  instr_data/instr_pc valid
- instr_ready  in  1  core consumes instruction
- instr_data  out  DATA_W  equals mem_do (RAM output register)
- instr_pc  out  ADDR_W  address of instr_data
- busy  out  1  state != IDLE
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_di  out  DATA_W  RAM write data
- mem_do  in  DATA_W  RAM read data

## Operation
- States: IDLE, LOAD, FETCH.
- IDLE:
  - load_start goes to LOAD, clears ld_ptr to 0.
  - Otherwise run_start goes to FETCH, sets pc to RESET_PC.
  - If both are asserted, load wins.
  - Starts are ignored outside IDLE.
- LOAD:
  - ld_ready=1.
  - A handshake (ld_valid&ld_ready) gives mem_en=1, mem_we=1, mem_addr=ld_ptr, mem_di=ld_data, and ld_ptr increments.
  - Exits to FETCH (pc=RESET_PC) when the accepted word has ld_last=1 or ld_ptr==2^ADDR_W-1. Excess words are never accepted.
- FETCH:
  - issue = !halt & !branch_en & (!instr_valid | instr_ready).
  - On issue: mem_en=1, mem_we=0, mem_addr=pc; next cycle pc<=pc+1 (mod 2^ADDR_W, 63 wraps to 0), instr_pc<=pc, instr_valid<=1.
  - No issue with instr_valid&instr_ready: instr_valid<=0.
  - Stall (instr_valid&!instr_ready): mem_en=0, so the RAM output register and instr_data hold.
  - branch_en: pc<=branch_target, instr_valid<=0 (the presented word is squashed even if instr_ready is high), no issue that cycle.
  - halt: go to IDLE, instr_valid<=0. halt beats branch_en.
- mem_en=0 and mem_we=0 in IDLE and on non-issue cycles. mem_we is never 1 outside LOAD.

## Timing
- Reset: state IDLE; ld_ready=0, instr_valid=0, instr_pc=0, pc=0, ld_ptr=0, busy=0, mem_en=mem_we=0, mem_addr=0, mem_di=0.
- Reset mid-LOAD aborts the load. Words already written stay in RAM.
- Outputs are registered except mem_* and ld_ready, which are combinational from state/inputs.
- Fetch latency is 1 cycle: issue at cycle t gives instr_valid/instr_data at t+1.
- Sustained throughput is 1 instruction/cycle with instr_ready held high.
- First FETCH issue happens on the cycle after the LOAD->FETCH or IDLE->FETCH transition.
- Load throughput is 1 word/cycle.
- A branch costs 1 bubble: the target's instruction is valid 2 cycles after branch_en.

## Configuration
- IMEM_LOAD_CHECKSUM_EN defined:
  - Adds output ld_checksum [DATA_W-1:0].
  - Cleared to 0 on entering LOAD.
  - Adds each accepted ld_data mod 2^DATA_W.
  - Holds its value afterwards.
  - Reset value 0.
- Undefined: the port and logic are absent. All other behaviour is identical.

## Structure
- Package imem_ctrl_pkg holds:
  - state enum typedef (IDLE, LOAD, FETCH)
  - default ADDR_W/DATA_W constants
  - RESET_PC default
- Checksum accumulator is the sub-module imem_ld_checksum, instantiated only under IMEM_LOAD_CHECKSUM_EN.
- The RAM is external, instantiated beside this block.

## Test plan
- Load then run: load_start, stream 0x1111,0x2222,0x3333 with last on the third -> RAM[0..2] written, FETCH entered. With instr_ready=1, instr_pc 0,1,2 and data 0x1111,0x2222,0x3333 appear on consecutive cycles.
- Full load without ld_last: 64 words are accepted, then ld_ready drops and state is FETCH. A further ld_valid is not accepted. Run continues 62 -> 63 -> 0 (wrap).
- Backpressure: instr_ready=0 for 3 cycles while instr_pc=5 -> mem_en=0, instr_data/instr_pc stable. Release gives 6 the next cycle.
- Branch: branch_en with target 0x20 while instr_pc=3 valid -> instr_valid=0 next cycle, then instr_pc=0x20 valid. Halt with branch_en in the same cycle -> IDLE, busy=0.
- Reset asserted mid-LOAD after 2 words -> outputs at reset values immediately. run_start then fetches the 2 written words from RESET_PC.
- With IMEM_LOAD_CHECKSUM_EN: load 0xFFFF,0x0002 -> ld_checksum=0x0001.
